// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and selectable read mode
// Flags decode from the count register only; overflow/underflow are registered one-cycle pulses.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 16,
  parameter int AF_LEVEL   = FIFO_SIZE - 4,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(FIFO_SIZE):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_WIDTH = $clog2(FIFO_SIZE);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] SIZE_CNT = CNT_WIDTH'(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (count_q == SIZE_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;

  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // Storage is not reset; pointers and count define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (flush) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem[rd_ptr];
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed self-checking bench for sync_fifo_prog
// Instance a runs registered-read mode, instance b runs first-word-fall-through.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       b_wr_en = 1'b0;
  logic       b_rd_en = 1'b0;
  logic [7:0] b_wdata = '0;
  logic [7:0] b_rdata;
  logic       b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow;
  logic [4:0] b_count;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_SIZE(16), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_SIZE(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .wr_en(b_wr_en), .wdata(b_wdata), .rd_en(b_rd_en),
    .rdata(b_rdata), .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_b_rdata", 32'(b_rdata), 0);
    rst_n = 1'b1;
    step();

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_af", 32'(almost_full), (i >= 12) ? 1 : 0);
      check("fill_full", 32'(full), (i == 16) ? 1 : 0);
    end
    wdata = 8'h11;
    step();
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    wr_en = 1'b0;
    step();
    check("ovf_clear", 32'(overflow), 0);

    // drain returns the first 16 words only
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_rdata", 32'(rdata), 32'(i));
      check("drain_count", 32'(count), 32'(16 - i));
      check("drain_ae", 32'(almost_empty), (16 - i <= 2) ? 1 : 0);
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 1);

    // underflow: one write, two reads
    wr_en = 1'b1; wdata = 8'h3c;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    check("unf_first", 32'(rdata), 32'h3c);
    check("unf_no_pulse", 32'(underflow), 0);
    step();
    check("unf_pulse", 32'(underflow), 1);
    check("unf_hold", 32'(rdata), 32'h3c);
    check("unf_count", 32'(count), 0);
    rd_en = 1'b0;
    step();
    check("unf_clear", 32'(underflow), 0);

    // simultaneous at empty: write taken, read rejected, no pass-through
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h77;
    step();
    check("se_count", 32'(count), 1);
    check("se_unf", 32'(underflow), 1);
    check("se_rdata", 32'(rdata), 32'h3c);
    wr_en = 1'b0;
    step();
    check("se_read", 32'(rdata), 32'h77);
    check("se_unf_gone", 32'(underflow), 0);
    rd_en = 1'b0;

    // simultaneous at full: read taken, write dropped
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h80 + i);
      step();
    end
    rd_en = 1'b1; wdata = 8'hee;
    step();
    check("sf_count", 32'(count), 15);
    check("sf_ovf", 32'(overflow), 1);
    check("sf_rdata", 32'(rdata), 32'h81);
    wr_en = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step();
      check("sf_drain", 32'(rdata), 32'(8'h80 + i));
    end
    rd_en = 1'b0;
    check("sf_empty", 32'(count), 0);

    // steady state at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h40 + i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h45 + k);
      step();
      check("ss_rdata", 32'(rdata), 32'(8'h40 + k));
      check("ss_count", 32'(count), 5);
    end
    wr_en = 1'b0;
    for (int k = 20; k < 25; k++) begin
      step();
      check("ss_tail", 32'(rdata), 32'(8'h40 + k));
    end
    rd_en = 1'b0;
    check("ss_end_count", 32'(count), 0);

    // flush with a concurrent write
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      step();
    end
    check("fl_pre", 32'(count), 9);
    flush = 1'b1;
    step();
    check("fl_count", 32'(count), 0);
    check("fl_empty", 32'(empty), 1);
    check("fl_ovf", 32'(overflow), 0);
    check("fl_rdata", 32'(rdata), 0);
    flush = 1'b0; wr_en = 1'b0;
    step();
    check("fl_idle_count", 32'(count), 0);

    // first-word-fall-through
    b_wr_en = 1'b1; b_wdata = 8'ha5;
    step();
    b_wr_en = 1'b0;
    check("fw_rdata", 32'(b_rdata), 32'ha5);
    check("fw_empty", 32'(b_empty), 0);
    b_rd_en = 1'b1;
    step();
    b_rd_en = 1'b0;
    check("fw_pop_rdata", 32'(b_rdata), 0);
    check("fw_pop_empty", 32'(b_empty), 1);
    b_wr_en = 1'b1; b_wdata = 8'h11;
    step();
    b_wdata = 8'h22;
    step();
    b_wr_en = 1'b0;
    check("fw_head", 32'(b_rdata), 32'h11);
    b_rd_en = 1'b1;
    step();
    b_rd_en = 1'b0;
    check("fw_next", 32'(b_rdata), 32'h22);
    check("fw_count", 32'(b_count), 1);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wdata = 8'(8'hc0 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("ar_pre_rdata", 32'(rdata), 32'hc0);
    wr_en = 1'b1; wdata = 8'hd0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_empty", 32'(empty), 1);
    check("ar_rdata", 32'(rdata), 0);
    check("ar_ae", 32'(almost_empty), 1);
    check("ar_b_empty", 32'(b_empty), 1);
    wr_en = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    check("ar_after", 32'(count), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
